memory_stage: RTL and testbench

- Consumer end of the execute-stage interface: latches the execute outputs into the M pipeline register, performs the Y86 data-memory access, and produces the memory-stage status.
- Provides M-register values and the read data to the writeback register and the forwarding logic.
- The data memory is byte-addressed and little-endian; every access is 64 bits.

---
 rtl/memory_stage.sv | 106 ++++++++++
 tb/tb_memory_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Y86 memory stage: M pipeline register, byte-addressed little-endian 64-bit
// data memory access, and memory-stage status generation.
module memory_stage #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        M_bubble,
  input  logic [1:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic        e_cnd,
  input  logic [63:0] e_valE,
  input  logic [63:0] E_valA,
  input  logic [3:0]  e_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [1:0]  W_stat,
  output logic [1:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic [63:0] m_valM,
  output logic [1:0]  m_stat
);

  localparam int          AW        = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

  logic [1:0]  r_M_stat;
  logic [3:0]  r_M_icode;
  logic        r_M_cnd;
  logic [63:0] r_M_valE;
  logic [63:0] r_M_valA;
  logic [3:0]  r_M_dstE;
  logic [3:0]  r_M_dstM;
  logic [7:0]  r_mem [0:MEM_BYTES-1];

  logic          w_is_rd;
  logic          w_is_wr;
  logic [63:0]   w_addr;
  logic          w_addr_ok;
  logic [AW-1:0] w_idx;
  logic [63:0]   w_rd_data;
  logic          w_wr_en;

  // Reset and bubble both insert a nop; reset wins over bubble.
  always_ff @(posedge clk) begin
    if (rst || M_bubble) begin
      r_M_stat  <= 2'd0;
      r_M_icode <= 4'h1;
      r_M_cnd   <= 1'b0;
      r_M_valE  <= '0;
      r_M_valA  <= '0;
      r_M_dstE  <= 4'hF;
      r_M_dstM  <= 4'hF;
    end else begin
      r_M_stat  <= E_stat;
      r_M_icode <= E_icode;
      r_M_cnd   <= e_cnd;
      r_M_valE  <= e_valE;
      r_M_valA  <= E_valA;
      r_M_dstE  <= e_dstE;
      r_M_dstM  <= E_dstM;
    end
  end

  // ret/popq address through valA; everything else through valE.
  always_comb begin
    w_is_rd   = (r_M_icode == 4'h5) || (r_M_icode == 4'h9) || (r_M_icode == 4'hB);
    w_is_wr   = (r_M_icode == 4'h4) || (r_M_icode == 4'hA) || (r_M_icode == 4'h8);
    w_addr    = ((r_M_icode == 4'h9) || (r_M_icode == 4'hB)) ? r_M_valA : r_M_valE;
    w_addr_ok = (w_addr <= LAST_ADDR);
    w_idx     = w_addr_ok ? w_addr[AW-1:0] : '0;
    w_wr_en   = w_is_wr && w_addr_ok && (r_M_stat == 2'd0) && (W_stat == 2'd0) && !rst;
  end

  // Index is clamped to zero on a bad address so idx+7 never leaves the array.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < 8; k++) begin
      w_rd_data[8*k +: 8] = r_mem[w_idx + AW'(k)];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[w_idx + AW'(k)] <= r_M_valA[8*k +: 8];
      end
    end
  end

  assign m_valM = (w_is_rd && w_addr_ok && (r_M_stat == 2'd0)) ? w_rd_data : '0;
  assign m_stat = ((r_M_stat == 2'd0) && (w_is_rd || w_is_wr) && !w_addr_ok) ? 2'd2 : r_M_stat;

  assign M_stat  = r_M_stat;
  assign M_icode = r_M_icode;
  assign M_cnd   = r_M_cnd;
  assign M_valE  = r_M_valE;
  assign M_valA  = r_M_valA;
  assign M_dstE  = r_M_dstE;
  assign M_dstM  = r_M_dstM;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed and random instruction streams checked
// against a byte-array memory model through an expected-response queue.
module tb_memory_stage;

  localparam int MEM_BYTES = 1024;
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

  logic        clk = 1'b0;
  logic        rst, M_bubble, e_cnd;
  logic [1:0]  E_stat, W_stat;
  logic [3:0]  E_icode, e_dstE, E_dstM;
  logic [63:0] e_valE, E_valA;
  logic [1:0]  M_stat, m_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic        M_cnd;
  logic [63:0] M_valE, M_valA, m_valM;

  memory_stage #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst(rst), .M_bubble(M_bubble), .E_stat(E_stat), .E_icode(E_icode),
    .e_cnd(e_cnd), .e_valE(e_valE), .E_valA(E_valA), .e_dstE(e_dstE), .E_dstM(E_dstM),
    .W_stat(W_stat), .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
    .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .m_valM(m_valM), .m_stat(m_stat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valM;
    logic [1:0]  mstat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mdl;
  logic [7:0] mdl_mem [MEM_BYTES];
  int n_checks = 0;
  int n_errors = 0;

  // Instruction-level view of memory: which icodes touch memory and where.
  function automatic bit is_read(input logic [3:0] ic);
    return ic == 4'h5 || ic == 4'h9 || ic == 4'hB;
  endfunction
  function automatic bit is_write(input logic [3:0] ic);
    return ic == 4'h4 || ic == 4'hA || ic == 4'h8;
  endfunction
  function automatic logic [63:0] addr_of(input exp_t m);
    return (m.icode == 4'h9 || m.icode == 4'hB) ? m.valA : m.valE;
  endfunction

  task automatic step(input logic r, input logic bub, input logic [1:0] es,
                      input logic [3:0] ic, input logic cnd, input logic [63:0] ve,
                      input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm,
                      input logic [1:0] ws);
    logic [63:0] a;
    @(negedge clk);
    rst = r; M_bubble = bub; E_stat = es; E_icode = ic; e_cnd = cnd;
    e_valE = ve; E_valA = va; e_dstE = de; E_dstM = dm; W_stat = ws;
    // The instruction now in M commits its store at the coming edge.
    a = addr_of(mdl);
    if (!r && ws == 2'd0 && mdl.stat == 2'd0 && is_write(mdl.icode) && a <= LAST)
      for (int k = 0; k < 8; k++) mdl_mem[int'(a) + k] = mdl.valA[8*k +: 8];
    if (r || bub) begin
      mdl.stat = 2'd0; mdl.icode = 4'h1; mdl.cnd = 1'b0; mdl.valE = '0;
      mdl.valA = '0; mdl.dstE = 4'hF; mdl.dstM = 4'hF;
    end else begin
      mdl.stat = es; mdl.icode = ic; mdl.cnd = cnd; mdl.valE = ve;
      mdl.valA = va; mdl.dstE = de; mdl.dstM = dm;
    end
    a = addr_of(mdl);
    mdl.valM = '0;
    if (is_read(mdl.icode) && a <= LAST && mdl.stat == 2'd0)
      for (int k = 0; k < 8; k++) mdl.valM[8*k +: 8] = mdl_mem[int'(a) + k];
    mdl.mstat = (mdl.stat == 2'd0 && (is_read(mdl.icode) || is_write(mdl.icode)) && a > LAST)
                ? 2'd2 : mdl.stat;
    exp_q.push_back(mdl);
  endtask

  task automatic op(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    step(1'b0, 1'b0, 2'd0, ic, 1'b0, ve, va, 4'hF, 4'hF, 2'd0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge after stimulus presents one M-stage result.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("M_stat",  64'(M_stat),  64'(e.stat));
      chk("M_icode", 64'(M_icode), 64'(e.icode));
      chk("M_cnd",   64'(M_cnd),   64'(e.cnd));
      chk("M_valE",  M_valE,       e.valE);
      chk("M_valA",  M_valA,       e.valA);
      chk("M_dstE",  64'(M_dstE),  64'(e.dstE));
      chk("M_dstM",  64'(M_dstM),  64'(e.dstM));
      chk("m_valM",  m_valM,       e.valM);
      chk("m_stat",  64'(m_stat),  64'(e.mstat));
    end
  end

  initial begin
    logic [3:0]  ic;
    logic [63:0] a, d;
    int r;
    for (int i = 0; i < MEM_BYTES; i++) mdl_mem[i] = 8'h00;
    mdl = '0;
    mdl.icode = 4'h1; mdl.dstE = 4'hF; mdl.dstM = 4'hF;
    rst = 1'b1; M_bubble = 1'b0; E_stat = 2'd0; E_icode = 4'h1; e_cnd = 1'b0;
    e_valE = '0; E_valA = '0; e_dstE = 4'hF; E_dstM = 4'hF; W_stat = 2'd0;

    // Reset with a store sitting in E.
    step(1'b1, 1'b0, 2'd0, 4'h4, 1'b1, 64'h10, 64'hDEAD, 4'h3, 4'h5, 2'd0);
    step(1'b1, 1'b0, 2'd0, 4'h4, 1'b0, 64'h10, 64'hDEAD, 4'hF, 4'hF, 2'd0);
    op(4'h5, 64'h10, 64'h0);
    // Store then load, plus byte-position probes.
    op(4'h4, 64'h10, 64'h1122334455667788);
    op(4'h5, 64'h10, 64'h0);
    op(4'h5, 64'h0A, 64'h0);
    op(4'h5, 64'h17, 64'h0);
    // push/pop at top of memory, then an out-of-range load.
    op(4'hA, 64'h3F8, 64'hABCD);
    op(4'hB, 64'h0, 64'h3F8);
    op(4'h5, 64'h3F9, 64'h0);
    // Huge address must not wrap into low memory.
    op(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF);
    op(4'h5, 64'h0, 64'h0);
    op(4'h5, 64'h3F8, 64'h0);
    // Store suppressed by HLT in writeback, then by its own INS status.
    op(4'h4, 64'h40, 64'h5555);
    step(1'b0, 1'b0, 2'd0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 2'd1);
    op(4'h5, 64'h40, 64'h0);
    step(1'b0, 1'b0, 2'd3, 4'h4, 1'b0, 64'h48, 64'h6666, 4'hF, 4'hF, 2'd0);
    op(4'h5, 64'h48, 64'h0);
    // Reset while a store is in M.
    op(4'h4, 64'h50, 64'h7777);
    step(1'b1, 1'b0, 2'd0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF, 2'd0);
    op(4'h5, 64'h50, 64'h0);
    // Bubble over irmovq, normal load, then reset+bubble together.
    step(1'b0, 1'b1, 2'd0, 4'h3, 1'b1, 64'h99, 64'h0, 4'h2, 4'hF, 2'd0);
    step(1'b0, 1'b0, 2'd0, 4'h3, 1'b1, 64'h99, 64'h0, 4'h2, 4'hF, 2'd0);
    step(1'b1, 1'b1, 2'd0, 4'h3, 1'b1, 64'h99, 64'h0, 4'h2, 4'hF, 2'd0);

    for (int n = 0; n < 400; n++) begin
      ic = 4'($urandom_range(0, 11));
      r = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, 127));
      else if (r == 7) a = LAST - 64'($urandom_range(0, 2));
      else if (r == 8) a = LAST + 64'($urandom_range(1, 8));
      else             a = {32'hFFFF_FFFF, 32'($urandom)};
      d = {32'($urandom), 32'($urandom)};
      step(($urandom_range(0, 40) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           ic, 1'($urandom), (ic == 4'h9 || ic == 4'hB) ? d : a,
           (ic == 4'h9 || ic == 4'hB) ? a : d,
           4'($urandom), 4'($urandom),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0);
    end

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
